// File: rtl/ram_burst_master.sv
// Burst initiator for the 64x8 single-port synchronous RAM: turns (addr, len, dir)
// commands into per-beat RAM accesses with valid/ready streaming on both data sides.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a command, cmd_ready high
// S_WRITE   | one RAM write per accepted wr beat, same edge as handshake
// S_RD_WAIT | address held while the RAM pipeline fills (RD_LAT edges)
// S_RD_OUT  | ram_q presented as rd_data until the consumer takes it
module ram_burst_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_ram_data,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    input  logic [DATA_W-1:0] i_ram_q
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RD_OUT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  r_wait;
    logic              w_last;
    logic              w_wait_done;

    assign w_last      = (r_remaining == '0);
    assign w_wait_done = (r_wait == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_next = i_cmd_write ? S_WRITE : S_RD_WAIT;
                end
            end
            S_WRITE: begin
                if (i_wr_valid && w_last) begin
                    w_next = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (w_wait_done) begin
                    w_next = S_RD_OUT;
                end
            end
            S_RD_OUT: begin
                if (i_rd_ready) begin
                    w_next = w_last ? S_IDLE : S_RD_WAIT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Burst address, beat counter and read-latency down-counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_wait      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_cur_addr  <= i_cmd_addr;
                        r_remaining <= i_cmd_len;
                        r_wait      <= WAIT_RELOAD;
                    end
                end
                S_WRITE: begin
                    if (i_wr_valid && !w_last) begin
                        r_cur_addr  <= r_cur_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - LEN_W'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (!w_wait_done) begin
                        r_wait <= r_wait - CNT_W'(1);
                    end
                end
                S_RD_OUT: begin
                    if (i_rd_ready && !w_last) begin
                        r_cur_addr  <= r_cur_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_wait      <= WAIT_RELOAD;
                    end
                end
                default: begin
                    r_wait <= '0;
                end
            endcase
        end
    end

    // Write strobe is gated by reset so an abort never lands a final beat.
    always_comb begin
        o_cmd_ready = 1'b0;
        o_wr_ready  = 1'b0;
        o_rd_valid  = 1'b0;
        o_rd_data   = '0;
        o_busy      = (r_state != S_IDLE);
        o_ram_addr  = r_cur_addr;
        o_ram_data  = '0;
        o_ram_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
            end
            S_WRITE: begin
                o_wr_ready = i_rst_n;
                o_ram_data = i_wr_data;
                o_ram_we   = i_wr_valid & i_rst_n;
            end
            S_RD_OUT: begin
                o_rd_valid = 1'b1;
                o_rd_data  = i_ram_q;
            end
            default: begin
                o_ram_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Randomised bench for ram_burst_master: a behavioural RAM plus an expected-memory
// array; every beat on either side is compared against that array.
module tb_ram_burst_master;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] exp_mem [64];
    logic [AW-1:0] ram_addr_r;
    logic          ram_init;
    logic [DW-1:0] seed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_burst_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(RL)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_write (cmd_write),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_len   (cmd_len),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_data   (wr_data),
        .o_rd_valid  (rd_valid),
        .i_rd_ready  (rd_ready),
        .o_rd_data   (rd_data),
        .o_busy      (busy),
        .o_ram_data  (ram_data),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .i_ram_q     (ram_q)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 13) ^ seed;
    endfunction

    // RAM: address registered on one edge, q registered on the next.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end
        ram_addr_r <= ram_addr;
        ram_q      <= mem[ram_addr_r];
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode: 0 continuous, 1 wr_valid alternating starting low, 2 random gaps
    task automatic do_write(input logic [AW-1:0] a, input int n, input int mode,
                            input logic [DW-1:0] base);
        int i = 0;
        int cyc = 0;
        logic v;
        logic [DW-1:0] d;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = LW'(n - 1);
        @(negedge clk);
        chk("wr_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_len = LW'($urandom);
        while (i < n && cyc < 200) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((cyc % 2) == 1) : 1'($urandom_range(0, 1));
            d = (mode == 2) ? DW'($urandom) : DW'(base + DW'(i));
            wr_valid = v;
            wr_data  = d;
            @(negedge clk);
            chk("wr_ready", wr_ready, 1);
            chk("wr_ram_we", ram_we, v);
            chk("wr_busy", busy, 1);
            if (v) begin
                chk("wr_ram_addr", ram_addr, AW'(a + AW'(i)));
                chk("wr_ram_data", ram_data, d);
                exp_mem[AW'(a + AW'(i))] = d;
                i++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        wr_valid = 1'b0;
        chk("wr_beats_done", i, n);
        @(negedge clk);
        chk("wr_end_busy", busy, 0);
        chk("wr_end_cmd_ready", cmd_ready, 1);
        chk("wr_end_we", ram_we, 0);
    endtask

    // mode: 0 rd_ready always high, 1 beat 1 held off 5 cycles, 2 random holds
    task automatic do_read(input logic [AW-1:0] a, input int n, input int mode);
        int beat = 0;
        int gap = 0;
        int hold = 0;
        int stall_len;
        int cyc = 0;
        logic prev_stalled = 1'b0;
        logic [AW-1:0] ea;
        stall_len = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = LW'(n - 1);
        @(negedge clk);
        chk("rd_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_len = LW'($urandom);
        while (beat < n && cyc < 300) begin
            rd_ready = (hold >= stall_len);
            @(negedge clk);
            ea = AW'(a + AW'(beat));
            if (prev_stalled) chk("rd_valid_held", rd_valid, 1);
            chk("rd_ram_we", ram_we, 0);
            chk("rd_wr_ready", wr_ready, 0);
            if (rd_valid) begin
                if (hold == 0) chk("rd_gap", gap, RL);
                chk("rd_data", rd_data, exp_mem[ea]);
                chk("rd_ram_addr", ram_addr, ea);
                if (rd_ready) begin
                    beat++;
                    gap = 0;
                    hold = 0;
                    prev_stalled = 1'b0;
                    stall_len = (mode == 1 && beat == 1) ? 5 :
                                (mode == 2) ? int'($urandom_range(0, 3)) : 0;
                end else begin
                    hold++;
                    prev_stalled = 1'b1;
                end
            end else begin
                gap++;
                prev_stalled = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rd_ready = 1'b0;
        chk("rd_beats_done", beat, n);
        @(negedge clk);
        chk("rd_end_busy", busy, 0);
        chk("rd_end_valid", rd_valid, 0);
    endtask

    task automatic reset_mid_write(input logic [AW-1:0] a);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = LW'(7);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_valid = 1'b1; wr_data = 8'hC1;
        @(negedge clk);
        chk("rst_beat1_we", ram_we, 1);
        exp_mem[a] = 8'hC1;
        @(posedge clk); #1;
        wr_data = 8'hC2; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_beat2_we", ram_we, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; wr_data = 8'hC3;
        @(negedge clk);
        chk("rst_after_busy", busy, 0);
        chk("rst_after_cmd_ready", cmd_ready, 1);
        chk("rst_after_we", ram_we, 0);
        chk("rst_after_wr_ready", wr_ready, 0);
        chk("rst_after_addr", ram_addr, 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        seed = DW'($urandom);
        for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
        ram_init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ram_init = 1'b0;
        rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = DW'($urandom);
            rd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_cmd_ready", cmd_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_we", ram_we, 0);
            chk("idle_rd_valid", rd_valid, 0);
            chk("idle_wr_ready", wr_ready, 0);
            chk("idle_ram_addr", ram_addr, 0);
            chk("idle_ram_data", ram_data, 0);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;

        do_write(6'h10, 4, 0, 8'hA1);
        do_read(6'h10, 4, 0);
        do_write(6'd62, 4, 0, 8'h01);
        do_read(6'd62, 4, 0);
        do_write(6'h30, 6, 1, 8'h50);
        do_read(6'h30, 6, 1);
        do_write(6'h05, 1, 0, 8'h77);
        do_read(6'h05, 1, 0);
        do_write(6'h3F, 16, 2, 8'h00);
        do_read(6'h3F, 16, 2);

        reset_mid_write(6'h20);
        do_read(6'h20, 8, 0);

        for (int k = 0; k < 12; k++) begin
            logic [AW-1:0] ra;
            int rn;
            ra = AW'($urandom);
            rn = int'($urandom_range(1, 16));
            if ($urandom_range(0, 1) == 1)
                do_write(ra, rn, int'($urandom_range(0, 2)), DW'($urandom));
            else
                do_read(ra, rn, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator for the team's 64x8 single-port synchronous RAM: drives the RAM data/addr/we pins and receives its registered q.
- Turns burst commands (start address, length, direction) into per-beat RAM accesses.
- Streams write data in and read data out over valid/ready handshakes.
- Sits between a processing engine and the RAM; the only agent on the RAM port.

Parameters:
- ADDR_W, 6, RAM address width (64 locations)
- DATA_W, 8, RAM data width
- LEN_W, 4, burst length field width; encoded beats = cmd_len+1 (1..16)
- RD_LAT, 2, clk edges from address presented (we low) to valid ram_q; RAM registers addr, then q

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  burst command present
- cmd_ready  out  1  master can accept a command (high only in IDLE)
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_W  burst start address
- cmd_len  in  LEN_W  beats minus one
- wr_valid  in  1  write beat data present
- wr_ready  out  1  write beat accepted this cycle
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat data present
- rd_ready  in  1  consumer accepts read beat
- rd_data  out  DATA_W  read beat data
- busy  out  1  burst in progress (state != IDLE)
- ram_data  out  DATA_W  to RAM data
- ram_addr  out  ADDR_W  to RAM addr
- ram_we  out  1  to RAM write enable
- ram_q  in  DATA_W  from RAM q

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, cur_addr=0, beat count=0, wait count=0.
- Outputs after reset: cmd_ready=1, wr_ready=0, rd_valid=0, busy=0, ram_we=0, ram_addr=0, ram_data=0.
- Reset mid-burst aborts immediately with no further ram_we pulse; beats not yet transferred are dropped.
- States: IDLE, WRITE, RD_WAIT, RD_OUT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cur_addr=cmd_addr, remaining=cmd_len. Go to WRITE if cmd_write=1, else to RD_WAIT with wait counter=RD_LAT-1.
  - ram_we=0 throughout IDLE.
- WRITE:
  - wr_ready=1.
  - ram_addr=cur_addr, ram_data=wr_data, ram_we=wr_valid, all combinational (the RAM writes on the same edge as the handshake).
  - On wr_valid: if remaining==0 go to IDLE; else cur_addr+1 and remaining-1.
  - wr_valid low stalls the burst indefinitely with ram_we=0.
- RD_WAIT:
  - ram_addr=cur_addr, ram_we=0, held for RD_LAT consecutive edges.
  - Count down; at 0 go to RD_OUT.
- RD_OUT:
  - rd_valid=1, rd_data=ram_q.
  - ram_addr held and ram_we=0, so q stays stable under backpressure.
  - On rd_ready: if remaining==0 go to IDLE; else cur_addr+1, remaining-1, return to RD_WAIT with reloaded counter.
  - Read throughput: one beat per RD_LAT+1 cycles minimum.
- Address arithmetic: cur_addr increments modulo 2^ADDR_W; a burst from 62 with len 3 (4 beats) touches 62, 63, 0, 1.
- ram_data must equal 0 whenever ram_we=0 outside WRITE, to keep the bus deterministic.
- cmd_valid outside IDLE is ignored (cmd_ready=0); no queueing.
- wr_valid outside WRITE is ignored; wr_ready is never high outside WRITE.
- rd_valid never drops once high until rd_ready.
- The 1-beat burst (cmd_len=0) is legal in both directions.
- Back-to-back: IDLE always takes one cycle between bursts.

Test Plan:
- Reset then idle -> cmd_ready=1, busy=0, ram_we=0, rd_valid=0, wr_ready=0 for 10 cycles.
- Write burst addr=0x10 len=3 with data A1,A2,A3,A4 continuous -> ram_we high 4 cycles at addr 0x10..0x13 with matching ram_data; then IDLE, busy=0.
- Read burst addr=0x10 len=3, rd_ready held high -> rd_data A1,A2,A3,A4, rd_valid first high RD_LAT+1 cycles after command accept, beats spaced 3 cycles.
- Wrap: write addr=62 len=3 data 01..04, then read back addr=62 len=3 -> addresses 62,63,0,1; data 01..04.
- Stalls: wr_valid toggled every other cycle and rd_ready held low 5 cycles mid-read -> no extra/missing ram_we pulses; rd_data stable while stalled; data intact.
- Reset asserted during beat 2 of an 8-beat write -> next cycle IDLE, ram_we=0; location of beat 3 keeps its prior value.
